// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing helpers
// used by both uart_rx and uart_tx.
package uart_pkg;

   localparam int unsigned DEF_CLK_FREQ = 25_000_000;
   localparam int unsigned DEF_BAUD     = 115_200;

   // Receiver FSM states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_rx_state_e;

   // Clocks per serial bit (integer division)
   function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                     input int unsigned baud);
      return clk_freq / baud;
   endfunction

   // Clocks from the start edge to the middle of the start bit
   function automatic int unsigned calc_half_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
      return calc_clks_per_bit(clk_freq, baud) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin, plus a falling-edge
// detect on the synchronised signal. All flops reset to the idle (high) level
// so that reset release never looks like a start edge.
module uart_rx_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic rx_i,
   output logic rx_s_o,
   output logic fall_c
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchroniser chain and one-cycle history for edge detection
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rx_s_o = sync_q;
   assign fall_c = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, mid-bit sampling.
// Optional even-parity checking is enabled with the macro UART_RX_PARITY_EN;
// without it the frame is 8N1 and parity_err is tied low.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
   parameter int unsigned BAUD     = DEF_BAUD
) (
   input  logic       clk_25mhz,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
   localparam int unsigned HALF_BIT     = calc_half_bit(CLK_FREQ, BAUD);
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

   logic rx_s;
   logic fall_c;

   uart_rx_sync u_sync (
      .clk_i  (clk_25mhz),
      .rst_i  (reset),
      .rx_i   (rx),
      .rx_s_o (rx_s),
      .fall_c (fall_c)
   );

   uart_rx_state_e   state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic [7:0]       data_q;
   logic             data_valid_q;
   logic             frame_err_q;
   logic             busy_q;

`ifdef UART_RX_PARITY_EN
   logic par_bit_q;
   logic parity_err_q;
   logic par_bad;

   // Even parity: data bits plus parity bit must XOR to zero
   assign par_bad = (^shift_q) ^ par_bit_q;
`endif

   // Receive FSM: bit timing, shifting and registered strobes
   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (fall_c) begin
                  cnt_q     <= '0;
                  bit_idx_q <= '0;
                  state_q   <= START;
                  busy_q    <= 1'b1;
               end
            end

            START: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q <= '0;
                  if (!rx_s) begin
                     state_q <= DATA;
                  end else begin
                     // Line back high at mid-start: glitch, not a frame
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            DATA: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q              <= '0;
                  shift_q[bit_idx_q] <= rx_s;
                  if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q     <= '0;
                  par_bit_q <= rx_s;
                  state_q   <= STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`endif

            STOP: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     // Return to IDLE mid-stop so a back-to-back start edge is caught
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                     if (par_bad) begin
                        parity_err_q <= 1'b1;
                     end else begin
                        data_q       <= shift_q;
                        data_valid_q <= 1'b1;
                     end
`else
                     data_q       <= shift_q;
                     data_valid_q <= 1'b1;
`endif
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= BREAK;
`ifdef UART_RX_PARITY_EN
                     parity_err_q <= par_bad;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            BREAK: begin
               // Held-low line: stay here until idle so only one frame_err fires
               if (rx_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
